// File: rtl/io_out_fifo_if.sv
// Processor write bus and consumer stream
// bundled for the output-port FIFO.
interface io_out_fifo_if #(
  parameter int NUBITS = 16,
  parameter int NUIOOU = 2
);
  localparam int AW =
    (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NUBITS-1:0] io_out;
  logic [AW-1:0]     addr_out;
  logic              out_en;
  logic [NUBITS-1:0] dout;
  logic              dvalid;
  logic              dready;

  modport master (
    output io_out, addr_out, out_en,
    output dready,
    input  dout, dvalid
  );

  modport slave (
    input  io_out, addr_out, out_en,
    input  dready,
    output dout, dvalid
  );
endinterface

// File: rtl/io_out_fifo.sv
// Output-port FIFO: captures writes to one port,
// streams them out, pulses itr_out on drain.
module io_out_fifo #(
  parameter int NUBITS = 16,
  parameter int NUIOOU = 2,
  parameter int PORTID = 0,
  parameter int DEPTH  = 8
) (
  input  logic clk,
  input  logic rst,
  io_out_fifo_if.slave bus,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic ovf,
  input  logic ovf_clr,
  output logic itr_out
);
  localparam int AW =
    (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [NUBITS-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic push;
  logic pop;
  logic acc;
  logic drop;

  assign push = bus.out_en &&
    (bus.addr_out == AW'(PORTID));
  assign pop  = bus.dvalid && bus.dready;
  // full is fine when a pop frees the slot
  assign acc  = push && (!full || pop);
  assign drop = push && full && !pop;

  assign bus.dvalid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign bus.dout   =
    bus.dvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (acc) begin
      mem[wr_ptr] <= bus.io_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      itr_out <= 1'b0;
    end else begin
      if (acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(acc) - CW'(pop);
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      itr_out <= pop && !acc &&
        (count == CW'(1));
    end
  end
endmodule

// File: tb/tb_io_out_fifo.sv
// Bench for io_out_fifo: vector table plus
// scoreboard-checked corner sequences.
module tb_io_out_fifo;
  localparam int NB = 16;
  localparam int DP = 8;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] count;
  logic full;
  logic ovf;
  logic ovf_clr;
  logic itr_out;

  io_out_fifo_if #(.NUBITS(NB), .NUIOOU(2)) bus();

  io_out_fifo #(
    .NUBITS(NB), .NUIOOU(2),
    .PORTID(0), .DEPTH(DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .count(count),
    .full(full),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .itr_out(itr_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] sbq [$];
  bit m_ovf = 1'b0;
  bit m_itr = 1'b0;
  logic [NB-1:0] last_pop;

  typedef struct {
    bit          r;
    bit          oe;
    bit          ad;
    logic [15:0] d;
    bit          dr;
    bit          clr;
    int          e_cnt;
    bit          e_ovf;
    bit          e_itr;
  } vec_t;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic set_in(bit r, bit oe, bit ad,
                        logic [15:0] d,
                        bit dr, bit clr);
    rst          = r;
    bus.out_en   = oe;
    bus.addr_out = ad;
    bus.io_out   = d;
    bus.dready   = dr;
    ovf_clr      = clr;
  endtask

  // One clock: model predicts, DUT steps, compare.
  task automatic cyc();
    int sz;
    bit mpop;
    bit mpush;
    bit acc;
    logic [NB-1:0] ed;
    sz = sbq.size();
    ed = (sz > 0) ? sbq[0] : '0;
    chk("dvalid", 32'(bus.dvalid), 32'(sz > 0));
    chk("dout", 32'(bus.dout), 32'(ed));
    mpop  = (sz > 0) && bus.dready;
    mpush = bus.out_en && (bus.addr_out == 1'b0);
    acc   = mpush && ((sz < DP) || mpop);
    if (rst) begin
      sbq.delete();
      m_ovf = 1'b0;
      m_itr = 1'b0;
    end else begin
      if (mpop) begin
        last_pop = bus.dout;
        void'(sbq.pop_front());
      end
      if (acc) sbq.push_back(bus.io_out);
      if (mpush && !acc) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_itr = mpop && !acc && (sz == 1);
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(sbq.size()));
    chk("full", 32'(full), 32'(sbq.size() == DP));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("itr", 32'(itr_out), 32'(m_itr));
  endtask

  task automatic drv(bit r, bit oe, bit ad,
                     logic [15:0] d,
                     bit dr, bit clr);
    set_in(r, oe, ad, d, dr, clr);
    cyc();
  endtask

  vec_t vt [11];

  initial begin
    vt[0]  = '{1,0,0,16'h0000,0,0, 0,0,0};
    vt[1]  = '{0,1,0,16'h0011,0,0, 1,0,0};
    vt[2]  = '{0,1,0,16'h0022,0,0, 2,0,0};
    vt[3]  = '{0,1,0,16'h0033,0,0, 3,0,0};
    vt[4]  = '{0,0,0,16'h0000,0,0, 3,0,0};
    vt[5]  = '{0,0,0,16'h0000,1,0, 2,0,0};
    vt[6]  = '{0,0,0,16'h0000,1,0, 1,0,0};
    vt[7]  = '{0,0,0,16'h0000,1,0, 0,0,1};
    vt[8]  = '{0,0,0,16'h0000,1,0, 0,0,0};
    vt[9]  = '{0,1,1,16'h0099,0,0, 0,0,0};
    vt[10] = '{0,0,0,16'h0000,0,0, 0,0,0};

    set_in(1, 0, 0, 16'h0, 0, 0);
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      if (i == 4) chk("v4_dout", 32'(bus.dout), 32'h11);
      drv(vt[i].r, vt[i].oe, vt[i].ad,
          vt[i].d, vt[i].dr, vt[i].clr);
      chk($sformatf("v%0d_cnt", i),
          32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_ovf", i),
          32'(ovf), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d_itr", i),
          32'(itr_out), 32'(vt[i].e_itr));
    end

    // overflow: word 9 dropped
    for (int k = 1; k <= 9; k++)
      drv(0, 1, 0, 16'(k), 0, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_cnt", 32'(count), 32'd8);
    chk("ovf_set", 32'(ovf), 32'd1);
    drv(0, 1, 0, 16'd10, 0, 1);
    chk("ovf_prio", 32'(ovf), 32'd1);
    drv(0, 0, 0, 16'd0, 0, 1);
    chk("ovf_clr", 32'(ovf), 32'd0);
    for (int k = 0; k < 9; k++)
      drv(0, 0, 0, 16'd0, 1, 0);
    chk("drain_last", 32'(last_pop), 32'd8);

    // full with simultaneous push and pop
    for (int k = 0; k < 8; k++)
      drv(0, 1, 0, 16'h0100 + 16'(k), 0, 0);
    drv(0, 1, 0, 16'hAAAA, 1, 0);
    chk("pp_cnt", 32'(count), 32'd8);
    chk("pp_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 9; k++)
      drv(0, 0, 0, 16'd0, 1, 0);
    chk("pp_last", 32'(last_pop), 32'hAAAA);

    // streaming with pointer wrap
    for (int k = 0; k < 20; k++) begin
      drv(0, 1, 0, 16'h2000 + 16'(k), 1, 0);
      chk("strm_cnt", 32'(count), 32'd1);
    end
    drv(1, 1, 0, 16'h3000, 1, 0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_dv", 32'(bus.dvalid), 32'd0);
    chk("rst_itr", 32'(itr_out), 32'd0);
    drv(0, 1, 0, 16'h5555, 0, 0);
    chk("rst_first", 32'(bus.dout), 32'h5555);
    drv(0, 0, 0, 16'd0, 1, 0);
    chk("rst_itr2", 32'(itr_out), 32'd1);
    drv(0, 0, 0, 16'd0, 0, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/io_out_fifo.md
# io_out_fifo

Output-port buffer between the processor's I/O write bus and an external consumer. Captures every word the processor writes to one configured output port address, stores it in a circular FIFO, and presents it on a valid/ready stream. Decouples the fixed-rate processor from a stalling consumer. Raises a one-cycle refill interrupt, intended for the processor's `itr` input, when the buffer drains.

## Interface
- NUBITS, 16, data word width; equals processor NUBITS
- NUIOOU, 2, number of processor output ports; sets `addr_out` width
- PORTID, 0, output port address this block captures; 0..NUIOOU-1
- DEPTH, 8, FIFO entries; power of two, ≥2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- io_out  in  NUBITS  processor write data
- addr_out  in  $clog2(NUIOOU)  processor output port address
- out_en  in  1  processor output write strobe
- dout  out  NUBITS  head-of-FIFO word; 0 when `dvalid`=0
- dvalid  out  1  FIFO non-empty
- dready  in  1  consumer accepts `dout` this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears `ovf`
- itr_out  out  1  one-cycle refill interrupt pulse

## Operation
- push = out_en && addr_out==PORTID; writes to other ports are ignored.
- pop = dvalid && dready.
- Storage: DEPTH×NUBITS array, no reset. Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate `count` register.
- Show-ahead read: dout = mem[rd_ptr] when count>0, else 0. No read latency.
- push accepted if count<DEPTH, or if count==DEPTH and pop happens in the same cycle. Accepted push: mem[wr_ptr]←io_out, wr_ptr+1.
- push with count==DEPTH and no pop: word dropped, pointers unchanged, ovf←1.
- pop: rd_ptr+1.
- count next = count + accepted_push − pop.
- Simultaneous push and pop when empty: pop cannot occur (dvalid=0); push accepted; count→1.
- Simultaneous push and pop when full: both occur; count stays DEPTH; no overflow.
- ovf: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- itr_out: registered. Asserts for exactly one cycle in the cycle after a pop takes count from 1 to 0. No pulse if a push in the same cycle keeps count at 1.
- No state machine beyond pointer/count control. The block never back-pressures the processor.

## Timing
- Reset (rst=1 at edge): wr_ptr=0, rd_ptr=0, count=0, ovf=0, itr_out=0. Hence dvalid=0, dout=0, full=0 after the edge.
- rst overrides any simultaneous push, pop, or ovf_clr. A word mid-transfer is lost.
- push at edge N: count, dvalid, and dout updated after edge N. Consumer can pop at edge N+1. Write-to-valid latency is 1 cycle.
- pop at edge N: next word (or dvalid=0) visible after edge N.
- dready may be held high continuously. dready while dvalid=0 has no effect.
- Sustained throughput: one push and one pop per cycle.
- full and dvalid are combinational decodes of the registered `count`. dout is combinational from storage and rd_ptr. No input-to-output combinational path exists.

## Test plan
- Reset, then push 0x0011, 0x0022, 0x0033 on port PORTID with dready=0 → count=3, dvalid=1, dout=0x0011. Raise dready for 3 cycles → dout sequence 0x0011, 0x0022, 0x0033; then dvalid=0, dout=0. itr_out=1 for exactly one cycle after the third pop.
- With PORTID=0, push on addr_out=1 → count stays 0, dvalid=0, no itr_out.
- DEPTH=8, dready=0, push 9 words 1..9 → full=1, count=8, ovf=1, word 9 dropped. Drain → words 1..8 in order. Assert ovf_clr together with a 10th push while full and no pop → ovf stays 1. ovf_clr alone → ovf=0.
- Fill to full, then push 0xAAAA and pop in the same cycle → count=8, ovf=0, 0xAAAA is the last word drained.
- Continuous push and dready for 20 cycles with incrementing data (pointer wrap) → output stream identical and gap-free after the first word, count stays 1. Pulse rst mid-stream → after the next edge count=0, dvalid=0, ovf=0, itr_out=0; next push data appears first.
